// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit execute stage: widths and opcode encodings.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int OPC_W  = 3;

  localparam logic [OPC_W-1:0] OP_ADD = 3'b000;
  localparam logic [OPC_W-1:0] OP_SUB = 3'b001;
  localparam logic [OPC_W-1:0] OP_AND = 3'b010;
  localparam logic [OPC_W-1:0] OP_OR  = 3'b011;
  localparam logic [OPC_W-1:0] OP_XOR = 3'b100;
  localparam logic [OPC_W-1:0] OP_MUL = 3'b101;
  localparam logic [OPC_W-1:0] OP_DIV = 3'b110;
  localparam logic [OPC_W-1:0] OP_CMP = 3'b111;

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU. The carry output doubles as the borrow,
// multiply-overflow and divide-by-zero flag depending on the opcode.
module alu8
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0]     sum;
  logic [2*DATA_W-1:0] product;

  assign sum     = {1'b0, a} + {1'b0, b};
  assign product = {8'b0, a} * {8'b0, b};

  // Select the operation; every path assigns both outputs.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_MUL: begin
        result = product[DATA_W-1:0];
        carry  = |product[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        if (b == '0) begin
          result = 8'hFF;
          carry  = 1'b1;
        end else begin
          result = a / b;
        end
      end
      OP_CMP: result = {5'b0, (a < b), (a > b), (a == b)};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instruction_memory.sv
// Registered execute stage: runs alu8 on the current operands, registers the
// result, flag and opcode, and keeps a per-opcode history of the last result.
// data_out returns the entry for this opcode as it was before this cycle's write.
module instruction_memory
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OPC_W-1:0]  opcode,
  output logic [OPC_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] result_out,
  output logic              carry_out,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic [DATA_W-1:0] mem [0:7];

  alu8 u_alu (
    .a      (a),
    .b      (b),
    .opcode (opcode),
    .result (alu_result),
    .carry  (alu_carry)
  );

  // Output registers and result memory; reset clears everything and suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alu_sel    <= '0;
      result_out <= '0;
      carry_out  <= 1'b0;
      data_out   <= '0;
      for (int i = 0; i < 8; i++) begin
        mem[i] <= '0;
      end
    end else begin
      alu_sel     <= opcode;
      result_out  <= alu_result;
      carry_out   <= alu_carry;
      data_out    <= mem[opcode];
      mem[opcode] <= alu_result;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Scoreboard bench for instruction_memory: the driver pushes hand-computed
// expectations per issued cycle, a monitor pops and compares after each edge.
module tb_instruction_memory;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] opcode = '0;
  logic [2:0] alu_sel;
  logic [7:0] result_out;
  logic       carry_out;
  logic [7:0] data_out;

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] res;
    logic       c;
    logic [7:0] data;
  } exp_t;

  exp_t       q[$];
  logic [7:0] mdl [0:7];
  int         n_tests = 0;
  int         n_fail  = 0;

  instruction_memory dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .opcode     (opcode),
    .alu_sel    (alu_sel),
    .result_out (result_out),
    .carry_out  (carry_out),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  task automatic do_rst();
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    a = 8'h5A; b = 8'h3C; opcode = 3'b000;
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    e = '{sel: 3'd0, res: 8'h00, c: 1'b0, data: 8'h00};
    q.push_back(e);
  endtask

  task automatic do_op(input logic [7:0] va, input logic [7:0] vb,
                       input logic [2:0] op, input logic [7:0] res,
                       input logic c);
    exp_t e;
    @(negedge clk);
    rst = 1'b1;
    a = va; b = vb; opcode = op;
    e = '{sel: op, res: res, c: c, data: mdl[op]};
    mdl[op] = res;
    q.push_back(e);
  endtask

  // Monitor: one expectation per edge, compared shortly after the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_tests++;
      if (alu_sel !== e.sel) begin
        n_fail++;
        $display("FAIL alu_sel: got %h expected %h", alu_sel, e.sel);
      end
      n_tests++;
      if (result_out !== e.res) begin
        n_fail++;
        $display("FAIL result_out (op %b): got %h expected %h", e.sel, result_out, e.res);
      end
      n_tests++;
      if (carry_out !== e.c) begin
        n_fail++;
        $display("FAIL carry_out (op %b): got %b expected %b", e.sel, carry_out, e.c);
      end
      n_tests++;
      if (data_out !== e.data) begin
        n_fail++;
        $display("FAIL data_out (op %b): got %h expected %h", e.sel, data_out, e.data);
      end
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    do_rst();
    do_rst();
    do_op(8'h00, 8'h00, 3'b111, 8'h01, 1'b0);
    do_op(8'h05, 8'h03, 3'b000, 8'h08, 1'b0);
    do_op(8'hFF, 8'h01, 3'b000, 8'h00, 1'b1);
    do_op(8'hCC, 8'hAA, 3'b001, 8'h22, 1'b0);
    do_op(8'h03, 8'h05, 3'b001, 8'hFE, 1'b1);
    do_op(8'h05, 8'h03, 3'b010, 8'h01, 1'b0);
    do_op(8'hCC, 8'hAA, 3'b011, 8'hEE, 1'b0);
    do_op(8'h05, 8'h03, 3'b100, 8'h06, 1'b0);
    do_op(8'hCC, 8'hAA, 3'b101, 8'h78, 1'b1);
    do_op(8'h05, 8'h03, 3'b110, 8'h01, 1'b0);
    do_op(8'h05, 8'h00, 3'b110, 8'hFF, 1'b1);
    do_op(8'hCC, 8'hAA, 3'b111, 8'h02, 1'b0);
    do_op(8'h0F, 8'h10, 3'b101, 8'hF0, 1'b0);
    do_op(8'h10, 8'h10, 3'b111, 8'h01, 1'b0);
    // back-to-back ADDs: second data_out must be the first result
    do_rst();
    do_op(8'h05, 8'h03, 3'b000, 8'h08, 1'b0);
    do_op(8'h01, 8'h01, 3'b000, 8'h02, 1'b0);
    // reset between the two ADDs wipes the history
    do_op(8'h05, 8'h03, 3'b000, 8'h08, 1'b0);
    do_rst();
    do_op(8'h01, 8'h01, 3'b000, 8'h02, 1'b0);
    do_op(8'h01, 8'h01, 3'b000, 8'h02, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
